// File: rtl/core_mem_pkg.sv
// Shared load/store encodings: access sizes, data-memory FSM states,
// the registered request record and lane helpers.
package core_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } dmem_state_e;

  typedef struct packed {
    logic        we;
    mem_size_e   size;
    logic        uns;
    logic        err;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;

  // Byte-lane write enables for a legal access at byte offset a.
  function automatic logic [3:0] lane_be(mem_size_e sz, logic [1:0] a);
    case (sz)
      SZ_BYTE: return 4'b0001 << a;
      SZ_HALF: return a[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Pick the addressed lane out of a RAM word, right-align and extend it.
  function automatic logic [31:0] load_extract(logic [31:0] w, mem_size_e sz,
                                               logic uns, logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (sz)
      SZ_BYTE: return uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: return uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

endpackage

// File: rtl/core_dmem_ram.sv
// Word-addressed single-port RAM, four byte lanes with individual write
// enables, synchronous read. Contents are deliberately not reset.
module core_dmem_ram #(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          CLK,
  input  logic          EN,
  input  logic          WE,
  input  logic [3:0]    BE,
  input  logic [AW-1:0] ADDR,
  input  logic [31:0]   WDATA,
  output logic [31:0]   RDATA
);

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] mem [DEPTH_WORDS];
    logic [7:0] rd_q;

    // Per-lane write with enable, registered read of the same word.
    always_ff @(posedge CLK) begin
      if (EN) begin
        if (WE && BE[l]) mem[ADDR] <= WDATA[8*l +: 8];
        rd_q <= mem[ADDR];
      end
    end

    assign RDATA[8*l +: 8] = rd_q;
  end

endmodule

// File: rtl/core_dmem.sv
// Core data memory: one outstanding load/store, IDLE -> ACCESS -> RESP,
// errors (bad size, misalignment, out of range) skip straight to RESP.
module core_dmem
  import core_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WE,
  input  logic [1:0]  REQ_SIZE,
  input  logic        REQ_UNSIGNED,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR
);

  localparam int         AW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

  dmem_state_e state, state_nxt;
  dmem_req_t   req_q;
  logic        accept;
  logic        req_err;
  logic [31:0] req_off;
  logic        ram_en, ram_we;
  logic [3:0]  ram_be;
  logic [AW-1:0] ram_addr;
  logic [31:0] ram_rdata;

  assign accept  = REQ_VALID & REQ_READY;
  assign req_off = REQ_ADDR - BASE_ADDR;

  // Error classification of the incoming request (range check is unsigned,
  // so addresses below BASE_ADDR wrap high and are rejected too).
  always_comb begin
    req_err = 1'b0;
    if (REQ_SIZE == SZ_ILL)                          req_err = 1'b1;
    if (REQ_SIZE == SZ_HALF && REQ_ADDR[0])          req_err = 1'b1;
    if (REQ_SIZE == SZ_WORD && REQ_ADDR[1:0] != 2'b00) req_err = 1'b1;
    if ({1'b0, req_off} >= SPAN)                     req_err = 1'b1;
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = req_err ? ST_RESP : ST_ACCESS;
      ST_ACCESS: state_nxt = ST_RESP;
      ST_RESP:   if (RSP_READY) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Capture the request on accept; held untouched until the next accept.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) req_q <= '0;
    else if (accept)
      req_q <= '{we: REQ_WE, size: mem_size_e'(REQ_SIZE), uns: REQ_UNSIGNED,
                 err: req_err, addr: REQ_ADDR, wdata: REQ_WDATA};
  end

  // Handshake and response outputs are pure functions of state + request,
  // so everything is stable across RESP and zero elsewhere.
  always_comb begin
    REQ_READY = (state == ST_IDLE);
    RSP_VALID = (state == ST_RESP);
    RSP_ERR   = (state == ST_RESP) & req_q.err;
    RSP_RDATA = '0;
    if (state == ST_RESP && !req_q.err && !req_q.we)
      RSP_RDATA = load_extract(ram_rdata, req_q.size, req_q.uns, req_q.addr[1:0]);
  end

  // RAM is touched only in ACCESS; reset held at the commit edge kills the store.
  assign ram_en   = (state == ST_ACCESS);
  assign ram_we   = ram_en & req_q.we & ~RST;
  assign ram_be   = lane_be(req_q.size, req_q.addr[1:0]);
  assign ram_addr = AW'((req_q.addr - BASE_ADDR) >> 2);

  core_dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_ram (
    .CLK   (CLK),
    .EN    (ram_en),
    .WE    (ram_we),
    .BE    (ram_be),
    .ADDR  (ram_addr),
    .WDATA (req_q.wdata),
    .RDATA (ram_rdata)
  );

endmodule

// File: tb/tb_core_dmem.sv
// Bench for core_dmem: directed scenarios plus random traffic against a
// byte-array memory model.
module tb_core_dmem;

  localparam int          D    = 1024;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ_VALID, REQ_READY, REQ_WE, REQ_UNSIGNED;
  logic [1:0]  REQ_SIZE;
  logic [31:0] REQ_ADDR, REQ_WDATA;
  logic        RSP_VALID, RSP_READY, RSP_ERR;
  logic [31:0] RSP_RDATA;

  int tests = 0;
  int fails = 0;
  logic [7:0]  rm [0:4*D-1];
  logic [31:0] last_rd;
  logic        last_err;

  always #5 CLK = ~CLK;

  core_dmem #(.DEPTH_WORDS(D), .BASE_ADDR(BASE)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
    .REQ_SIZE(REQ_SIZE), .REQ_UNSIGNED(REQ_UNSIGNED), .REQ_ADDR(REQ_ADDR),
    .REQ_WDATA(REQ_WDATA), .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---- reference model: memory as a flat byte array ----
  function automatic logic m_err(logic [1:0] sz, logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
           (sz == 2'b10 && a[1:0] != 2'b00) || (off >= 32'(D*4));
  endfunction

  function automatic int m_len(logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] m_load(logic [1:0] sz, logic uns, logic [31:0] a);
    int off, n;
    logic [31:0] v;
    off = int'(a - BASE);
    n   = m_len(sz);
    v   = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rm[off+i];
    if (!uns && n == 1) v = {{24{v[7]}}, v[7:0]};
    if (!uns && n == 2) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic m_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int off;
    off = int'(a - BASE);
    for (int i = 0; i < m_len(sz); i++) rm[off+i] = wd[8*((off+i)%4) +: 8];
  endtask

  // One complete request/response; lat counts edges from accept to first RSP_VALID.
  task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int lat);
    int n;
    n = 0;
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_WE = we; REQ_SIZE = sz; REQ_UNSIGNED = uns;
    REQ_ADDR = a; REQ_WDATA = wd;
    while (!REQ_READY && n < 10) begin @(negedge CLK); n++; end
    @(posedge CLK);
    @(negedge CLK);
    REQ_VALID = 1'b0;
    lat = 1;
    while (!RSP_VALID && lat < 10) begin @(negedge CLK); lat++; end
    rd = RSP_RDATA; er = RSP_ERR;
    RSP_READY = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RSP_READY = 1'b0;
  endtask

  task automatic run(input string tag, input logic we, input logic [1:0] sz,
                     input logic uns, input logic [31:0] a, input logic [31:0] wd);
    logic        e_err, er;
    logic [31:0] e_rd, rd;
    int          lat;
    e_err = m_err(sz, a);
    e_rd  = (we || e_err) ? 32'h0 : m_load(sz, uns, a);
    xact(we, sz, uns, a, wd, rd, er, lat);
    chk({tag, ".rdata"}, rd, e_rd);
    chk({tag, ".err"}, 32'(er), 32'(e_err));
    chk({tag, ".lat"}, 32'(lat), e_err ? 32'd1 : 32'd2);
    if (we && !e_err) m_store(sz, a, wd);
    last_rd = rd; last_err = er;
  endtask

  initial begin
    logic [31:0] d0, wd;
    logic [1:0]  sz;
    int          r, n;
    for (int i = 0; i < 4*D; i++) rm[i] = 8'h00;
    RST = 1'b1; REQ_VALID = 1'b0; REQ_WE = 1'b0; REQ_SIZE = 2'b00;
    REQ_UNSIGNED = 1'b0; REQ_ADDR = '0; REQ_WDATA = '0; RSP_READY = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst.rsp_valid", 32'(RSP_VALID), 32'd0);
    chk("rst.rdata", RSP_RDATA, 32'h0);
    chk("rst.err", 32'(RSP_ERR), 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst.req_ready", 32'(REQ_READY), 32'd1);

    // Known-zero window for everything read later.
    for (int w = 0; w < 64; w++) run("init", 1'b1, 2'b10, 1'b0, 32'(w*4), 32'h0);

    // Word store/load.
    run("sw10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    run("lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("lw10.const", last_rd, 32'hDEADBEEF);

    // Byte lanes.
    run("sw10z", 1'b1, 2'b10, 1'b0, 32'h10, 32'h0);
    run("sb13", 1'b1, 2'b00, 1'b0, 32'h13, 32'h80808080);
    run("lb13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    chk("lb13.const", last_rd, 32'hFFFFFF80);
    run("lbu13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    chk("lbu13.const", last_rd, 32'h00000080);
    run("lw10b", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("lw10b.const", last_rd, 32'h80000000);

    // Half store over a known word.
    run("sw20", 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D);
    run("sh22", 1'b1, 2'b01, 1'b0, 32'h22, 32'h12341234);
    run("lh22", 1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
    chk("lh22.const", last_rd, 32'h00001234);
    run("lw20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    chk("lw20.const", last_rd, 32'h1234F00D);

    // Errors and range boundary.
    run("lw11", 1'b0, 2'b10, 1'b0, 32'h11, 32'h0);
    chk("lw11.errc", 32'(last_err), 32'd1);
    run("lh21", 1'b0, 2'b01, 1'b0, 32'h21, 32'h0);
    run("sz11", 1'b0, 2'b11, 1'b0, 32'h30, 32'h0);
    run("lwoor", 1'b0, 2'b10, 1'b0, 32'(D*4), 32'h0);
    chk("lwoor.errc", 32'(last_err), 32'd1);
    run("sw11", 1'b1, 2'b10, 1'b0, 32'h11, 32'hFFFFFFFF);
    run("lw10c", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("lw10c.const", last_rd, 32'h80000000);
    run("swtop", 1'b1, 2'b10, 1'b0, 32'(D*4-4), 32'h5A5A1234);
    run("lwtop", 1'b0, 2'b10, 1'b0, 32'(D*4-4), 32'h0);
    chk("lwtop.const", last_rd, 32'h5A5A1234);

    // Backpressure: response held, new requests ignored.
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_SIZE = 2'b10; REQ_ADDR = 32'h10;
    @(posedge CLK);
    @(negedge CLK);
    REQ_VALID = 1'b0;
    n = 0;
    while (!RSP_VALID && n < 10) begin @(negedge CLK); n++; end
    d0 = RSP_RDATA;
    chk("bp.first", d0, 32'h80000000);
    for (int k = 0; k < 5; k++) begin
      REQ_VALID = k[0]; REQ_WE = 1'b1; REQ_ADDR = 32'h10; REQ_WDATA = 32'h11111111;
      @(posedge CLK);
      @(negedge CLK);
      chk("bp.valid", 32'(RSP_VALID), 32'd1);
      chk("bp.data", RSP_RDATA, d0);
      chk("bp.req_ready", 32'(REQ_READY), 32'd0);
    end
    REQ_VALID = 1'b0; RSP_READY = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RSP_READY = 1'b0;
    chk("bp.drop", 32'(RSP_VALID), 32'd0);
    run("bp.lw", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("bp.lw.const", last_rd, 32'h80000000);

    // Reset in ACCESS discards the store.
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_SIZE = 2'b10; REQ_ADDR = 32'h40;
    REQ_WDATA = 32'hA5A5A5A5;
    @(posedge CLK);
    @(negedge CLK);
    REQ_VALID = 1'b0;
    RST = 1'b1;
    #1;
    chk("rac.req_ready", 32'(REQ_READY), 32'd1);
    chk("rac.valid", 32'(RSP_VALID), 32'd0);
    chk("rac.rdata", RSP_RDATA, 32'h0);
    chk("rac.err", 32'(RSP_ERR), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    run("rac.lw", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    chk("rac.lw.const", last_rd, 32'h0);

    // Random traffic against the model.
    for (int t = 0; t < 300; t++) begin
      r  = int'($urandom_range(0, 15));
      sz = (r == 15) ? 2'b11 : 2'(r % 3);
      wd = $urandom;
      if (sz == 2'b00) wd = {4{wd[7:0]}};
      if (sz == 2'b01) wd = {2{wd[15:0]}};
      run("rnd", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
          ($urandom_range(0, 9) == 0) ? 32'(D*4) + $urandom_range(0, 255)
                                      : 32'($urandom_range(0, 255)),
          wd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
